// File: rtl/urv_dmem_responder.sv
// uRV data-memory responder: synchronous word SRAM behind an IDLE/WAIT/RESP handshake with WAIT_STATES extra cycles.
// Optional macro DMEM_ERR_EN adds dm_error_o and rejects addresses above the memory range.
module urv_dmem_responder #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o
`ifdef DMEM_ERR_EN
    ,
    output logic        dm_error_o
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam int         DEPTH   = 1 << ADDR_WIDTH;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_data;
    logic [3:0]            r_sel;
    logic                  r_is_store;
    logic                  r_err;
    logic [31:0]           r_rd_q;
    logic                  r_rd_zero;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_req;
    logic                  w_new_err;
    logic                  w_access;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [31:0]           w_acc_data;
    logic [3:0]            w_acc_sel;
    logic                  w_acc_store;
    logic                  w_acc_err;
    logic                  w_unused;

    assign w_idle = (r_state == ST_IDLE);
    assign w_req  = dm_load_i | dm_store_i;

`ifdef DMEM_ERR_EN
    assign w_new_err  = |dm_addr_i[31:ADDR_WIDTH+2];
    assign dm_error_o = (r_state == ST_RESP) && r_err;
`else
    assign w_new_err  = 1'b0;
`endif
    assign w_unused = &{1'b0, dm_addr_i[1:0], dm_addr_i[31:ADDR_WIDTH+2]};

    // With zero wait states the access uses the live request on the sampling edge, otherwise the latched copy.
    assign w_acc_addr  = w_idle ? dm_addr_i[ADDR_WIDTH+1:2] : r_addr;
    assign w_acc_data  = w_idle ? dm_data_s_i               : r_data;
    assign w_acc_sel   = w_idle ? dm_data_select_i          : r_sel;
    assign w_acc_store = w_idle ? dm_store_i                : r_is_store;
    assign w_acc_err   = w_idle ? w_new_err                 : r_err;

    assign w_access = (w_idle && w_req && (WAIT_STATES == 0)) ||
                      ((r_state == ST_WAIT) && (r_cnt == 4'd0));
    // The SRAM has no reset, so a write must be suppressed explicitly while reset is held.
    assign w_wr_en  = w_access && w_acc_store && !w_acc_err && rst_n_i;
    assign w_rd_en  = w_access && !w_acc_store && !w_acc_err;

    // NOTE: the SRAM array is deliberately kept out of the reset domain; resetting it would forbid RAM inference.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (w_acc_sel[n]) begin
                    r_mem[w_acc_addr][8*n +: 8] <= w_acc_data[8*n +: 8];
                end
            end
        end
        if (w_rd_en) begin
            r_rd_q <= r_mem[w_acc_addr];
        end
    end

    // NOTE: every state register uses non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_data     <= 32'd0;
            r_sel      <= 4'd0;
            r_is_store <= 1'b0;
            r_err      <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_addr     <= dm_addr_i[ADDR_WIDTH+1:2];
                        r_data     <= dm_data_s_i;
                        r_sel      <= dm_data_select_i;
                        r_is_store <= dm_store_i;
                        r_err      <= w_new_err;
                        if (WAIT_STATES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_cnt   <= 4'(WAIT_STATES - 1);
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            // An erroring load forces the read word to zero; stores leave it untouched.
            if (w_access && !w_acc_store) begin
                r_rd_zero <= w_acc_err;
            end
        end
    end

    assign dm_data_l_o     = r_rd_zero ? 32'd0 : r_rd_q;
    assign dm_load_done_o  = (r_state == ST_RESP) && !r_is_store;
    assign dm_store_done_o = (r_state == ST_RESP) && r_is_store;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Bench for urv_dmem_responder: two instances (0 and 3 wait states) checked every cycle against a transaction-level model.
// Build with DMEM_ERR_EN defined to also exercise the error path.
module tb_urv_dmem_responder;

    localparam int NDUT = 2;
    localparam int AW0  = 12;
    localparam int AW1  = 6;
    localparam int WS0  = 0;
    localparam int WS1  = 3;
`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [NDUT];
    logic [31:0] b_addr  [NDUT];
    logic [31:0] b_wdata [NDUT];
    logic [3:0]  b_sel   [NDUT];
    logic        b_load  [NDUT];
    logic        b_store [NDUT];
    logic [31:0] q_data  [NDUT];
    logic        q_ld    [NDUT];
    logic        q_st    [NDUT];
`ifdef DMEM_ERR_EN
    logic        q_err   [NDUT];
`endif

    urv_dmem_responder #(.ADDR_WIDTH(AW0), .WAIT_STATES(WS0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .dm_addr_i(b_addr[0]), .dm_data_s_i(b_wdata[0]),
        .dm_data_select_i(b_sel[0]), .dm_load_i(b_load[0]), .dm_store_i(b_store[0]),
        .dm_data_l_o(q_data[0]), .dm_load_done_o(q_ld[0]), .dm_store_done_o(q_st[0])
`ifdef DMEM_ERR_EN
        , .dm_error_o(q_err[0])
`endif
    );

    urv_dmem_responder #(.ADDR_WIDTH(AW1), .WAIT_STATES(WS1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .dm_addr_i(b_addr[1]), .dm_data_s_i(b_wdata[1]),
        .dm_data_select_i(b_sel[1]), .dm_load_i(b_load[1]), .dm_store_i(b_store[1]),
        .dm_data_l_o(q_data[1]), .dm_load_done_o(q_ld[1]), .dm_store_done_o(q_st[1])
`ifdef DMEM_ERR_EN
        , .dm_error_o(q_err[1])
`endif
    );

    // ---------------- reference model state ----------------
    int          cyc = 0;
    logic [31:0] mem_m [int];
    int          pend_done [NDUT];
    bit          pend_load [NDUT];
    bit          pend_err  [NDUT];
    int          pend_key  [NDUT];
    logic [31:0] pend_wd   [NDUT];
    logic [3:0]  pend_sel  [NDUT];
    logic [31:0] exp_data  [NDUT];
    int          idle_from [NDUT];
    int          n_checks = 0;
    int          n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int aw_of(input int d);
        return (d == 0) ? AW0 : AW1;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic int key_of(input int d, input logic [31:0] a);
        return d * 65536 + int'((a >> 2) & ((32'd1 << aw_of(d)) - 32'd1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: each falling edge, decide from the pending transaction what every output must be.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            bit          e_ld;
            bit          e_st;
            bit          e_err;
            logic [31:0] w;
            e_ld  = 1'b0;
            e_st  = 1'b0;
            e_err = 1'b0;
            if (!rst_n[d]) begin
                pend_done[d] = -1;
                exp_data[d]  = 32'd0;
            end else if (pend_done[d] == cyc) begin
                e_ld  = pend_load[d];
                e_st  = !pend_load[d];
                e_err = pend_err[d];
                if (e_ld) exp_data[d] = pend_err[d] ? 32'd0 : mem_m[pend_key[d]];
                if (e_st && !pend_err[d]) begin
                    w = mem_m[pend_key[d]];
                    for (int n = 0; n < 4; n++)
                        if (pend_sel[d][n]) w[8*n +: 8] = pend_wd[d][8*n +: 8];
                    mem_m[pend_key[d]] = w;
                end
            end
            check($sformatf("dut%0d_load_done", d), 32'(q_ld[d]), 32'(e_ld));
            check($sformatf("dut%0d_store_done", d), 32'(q_st[d]), 32'(e_st));
            check($sformatf("dut%0d_data_l", d), q_data[d], exp_data[d]);
`ifdef DMEM_ERR_EN
            check($sformatf("dut%0d_error", d), 32'(q_err[d]), 32'(e_err));
`endif
        end
    end

    // All driver activity happens 1 time unit after the falling edge, after the compare process.
    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset(input int d, input int cycles);
        rst_n[d]   = 1'b0;
        b_load[d]  = 1'b0;
        b_store[d] = 1'b0;
        wait_until(cyc + cycles);
        rst_n[d]     = 1'b1;
        idle_from[d] = 0;
    endtask

    // One requester transaction: hold the request until the done cycle (optionally dropping it
    // right after sampling, or resetting the DUT abort_at cycles after sampling).
    task automatic xact(input int d, input bit ld, input bit st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sel, input bit drop, input int abort_at);
        int s;
        s = (cyc + 1 > idle_from[d]) ? cyc + 1 : idle_from[d];
        b_addr[d]  = a;
        b_wdata[d] = wd;
        b_sel[d]   = sel;
        b_load[d]  = ld;
        b_store[d] = st;
        pend_done[d] = s + ws_of(d);
        pend_load[d] = ld && !st;
        pend_err[d]  = ERR_EN && ((a >> (aw_of(d) + 2)) != 32'd0);
        pend_key[d]  = key_of(d, a);
        pend_wd[d]   = wd;
        pend_sel[d]  = sel;
        if (abort_at >= 0) begin
            wait_until(s + abort_at);
            pulse_reset(d, 2);
            return;
        end
        if (drop && ws_of(d) > 0) begin
            wait_until(s);
            b_load[d]  = 1'b0;
            b_store[d] = 1'b0;
            b_addr[d]  = $urandom();
            b_wdata[d] = $urandom();
            b_sel[d]   = 4'($urandom());
        end
        wait_until(pend_done[d]);
        b_load[d]    = 1'b0;
        b_store[d]   = 1'b0;
        idle_from[d] = pend_done[d] + 2;
    endtask

    task automatic run_random(input int d, input int count, input int pool);
        for (int i = 0; i < count; i++) begin
            int          r;
            int          idx;
            logic [31:0] hi;
            logic [31:0] a;
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, pool - 1);
            hi  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom();
            a   = (hi << (aw_of(d) + 2)) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
            xact(d, (r < 4) || (r >= 8), r >= 4, a, $urandom(), 4'($urandom()),
                 $urandom_range(0, 3) == 0, -1);
            if ($urandom_range(0, 2) == 0) wait_until(cyc + $urandom_range(1, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst_n[d]     = 1'b0;
            b_addr[d]    = 32'd0;
            b_wdata[d]   = 32'd0;
            b_sel[d]     = 4'd0;
            b_load[d]    = 1'b0;
            b_store[d]   = 1'b0;
            pend_done[d] = -1;
            exp_data[d]  = 32'd0;
            idle_from[d] = 0;
        end
        @(negedge clk);
        #1;
        wait_until(3);
        check("reset_data0", q_data[0], 32'd0);
        check("reset_data1", q_data[1], 32'd0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Pre-fill every word either instance will read.
        for (int i = 0; i < 16; i++) xact(0, 1'b0, 1'b1, 32'(i) << 2, $urandom(), 4'hF, 1'b0, -1);
        for (int i = 0; i < 64; i++) xact(1, 1'b0, 1'b1, 32'(i) << 2, $urandom(), 4'hF, 1'b0, -1);

        // Zero wait states: full-word store then load.
        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, -1);
        check("t1_store_done", 32'(q_st[0]), 32'd1);
        xact(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, -1);
        check("t1_load_done", 32'(q_ld[0]), 32'd1);
        check("t1_data", q_data[0], 32'hDEADBEEF);
        check("t1_model", exp_data[0], 32'hDEADBEEF);

        // Single-lane store merges into the existing word; empty select writes nothing.
        xact(0, 1'b0, 1'b1, 32'h11, 32'h0000AA00, 4'b0010, 1'b0, -1);
        xact(0, 1'b0, 1'b1, 32'h10, 32'h11111111, 4'b0000, 1'b0, -1);
        xact(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, -1);
        check("t2_data", q_data[0], 32'hDEADAAEF);

        // Load and store together: the store wins.
        xact(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, -1);
        check("t4_store_done", 32'(q_st[0]), 32'd1);
        check("t4_no_load_done", 32'(q_ld[0]), 32'd0);
        xact(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, -1);
        check("t4_data", q_data[0], 32'h12345678);

        // Three wait states: pulse width, data hold, back-to-back acceptance.
        xact(1, 1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 1'b0, -1);
        xact(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, -1);
        check("t3_load_done", 32'(q_ld[1]), 32'd1);
        check("t3_data", q_data[1], 32'hCAFEF00D);
        wait_until(cyc + 1);
        check("t3_pulse_end", 32'(q_ld[1]), 32'd0);
        check("t3_data_held", q_data[1], 32'hCAFEF00D);
        xact(1, 1'b1, 1'b0, 32'h14, 32'd0, 4'h0, 1'b0, -1);
        xact(1, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, 1'b1, -1);
        xact(1, 1'b1, 1'b0, 32'h14, 32'd0, 4'h0, 1'b1, -1);
        check("t3_dropped_req", q_data[1], 32'h0BADF00D);

        // Reset during WAIT abandons the store.
        xact(1, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, 1'b0, 1);
        check("t5_data_rst", q_data[1], 32'd0);
        check("t5_no_done", 32'({q_ld[1], q_st[1]}), 32'd0);
        xact(1, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b0, -1);
        check("t5_mem_kept", q_data[1], 32'hCAFEF00D);

        // Address wrap: bits above the memory range are ignored.
        xact(1, 1'b1, 1'b0, 32'h0000_0110, 32'd0, 4'h0, 1'b0, -1);
`ifdef DMEM_ERR_EN
        check("wrap_err_data", q_data[1], 32'd0);

        xact(0, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 4'h0, 1'b0, -1);
        check("t6_error", 32'(q_err[0]), 32'd1);
        check("t6_load_done", 32'(q_ld[0]), 32'd1);
        check("t6_data", q_data[0], 32'd0);
        xact(0, 1'b0, 1'b1, 32'h8000_0020, 32'h55555555, 4'hF, 1'b0, -1);
        xact(0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h0, 1'b0, -1);
        check("t6_mem_kept", q_data[0], 32'h12345678);
`else
        check("wrap_data", q_data[1], 32'hCAFEF00D);
`endif

        run_random(0, 300, 16);
        run_random(1, 200, 64);
        wait_until(cyc + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
